// File: rtl/rt_pkg.sv
// Shared definitions for the ray-tracing host driver: camera payload layout
// and the driver state encoding.
package rt_pkg;

  localparam int CameraPayloadSize = 27;

  localparam int OFF_IMAGE_WIDTH  = 1;
  localparam int OFF_IMAGE_HEIGHT = 2;
  localparam int OFF_PIXEL_00_LOC = 24;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_CFG = 2'd1,
    ST_RECV_PIX = 2'd2,
    ST_FINISH   = 2'd3
  } drv_state_e;

endpackage

// File: rtl/rt_scene_driver_if.sv
// AXI4-Stream link bundle used for both the config stream and the fragment stream.
interface rt_scene_driver_if #(
  parameter int WORD_LEN = 32
);
  logic                tvalid;
  logic [WORD_LEN-1:0] tdata;
  logic                tlast;
  logic                tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/rt_cfg_regfile.sv
// Camera payload register file: one write port, one streamed-word read port
// and a dedicated width/height read port.
module rt_cfg_regfile
  import rt_pkg::*;
#(
  parameter int WORD_LEN = 32
) (
  input  logic                aclk,
  input  logic                resetn,
  input  logic                we,
  input  logic [4:0]          waddr,
  input  logic [WORD_LEN-1:0] wdata,
  input  logic [4:0]          raddr,
  output logic [WORD_LEN-1:0] rdata,
  output logic [15:0]         width,
  output logic [15:0]         height
);

  logic [WORD_LEN-1:0] regs [CameraPayloadSize];

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CameraPayloadSize; i++) regs[i] <= '0;
    end else if (we && (waddr < 5'(CameraPayloadSize))) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata  = (raddr < 5'(CameraPayloadSize)) ? regs[raddr] : '0;
  assign width  = regs[OFF_IMAGE_WIDTH][15:0];
  assign height = regs[OFF_IMAGE_HEIGHT][15:0];

endmodule

// File: rtl/rt_scene_driver.sv
// Host-side driver: streams the camera payload to the coprocessor, then sinks
// the returned fragments into the frame buffer and checks count/tlast.
module rt_scene_driver
  import rt_pkg::*;
#(
  parameter int WORD_LEN      = 32,
  parameter int PAYLOAD_WORDS = 27,
  parameter int FB_AW         = 20
) (
  input  logic                aclk,
  input  logic                resetn,
  input  logic                cfg_we,
  input  logic [4:0]          cfg_addr,
  input  logic [WORD_LEN-1:0] cfg_wdata,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err_dim,
  output logic                err_early,
  output logic                err_nolast,
  output logic [FB_AW-1:0]    pixel_count,
  rt_scene_driver_if.master   m_axis,
  rt_scene_driver_if.slave    s_axis,
  output logic                fb_we,
  output logic [FB_AW-1:0]    fb_addr,
  output logic [WORD_LEN-1:0] fb_wdata
);

  localparam logic [4:0] LAST_IDX = 5'(PAYLOAD_WORDS - 1);

  drv_state_e          state;
  logic [4:0]          idx;
  logic [FB_AW-1:0]    expected;
  logic                m_valid;
  logic                s_ready;
  logic [WORD_LEN-1:0] rd_word;
  logic [15:0]         width;
  logic [15:0]         height;
  logic [FB_AW-1:0]    area;
  logic [FB_AW-1:0]    cnt_next;
  logic                accept;
  logic                is_final;
  logic                is_early;

  rt_cfg_regfile #(.WORD_LEN(WORD_LEN)) u_regfile (
    .aclk   (aclk),
    .resetn (resetn),
    .we     (cfg_we && !busy),
    .waddr  (cfg_addr),
    .wdata  (cfg_wdata),
    .raddr  (idx),
    .rdata  (rd_word),
    .width  (width),
    .height (height)
  );

  assign area = FB_AW'({16'd0, width} * {16'd0, height});

  // idx only moves on a handshake, so tdata/tlast hold while the slave stalls
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = m_valid ? rd_word : '0;
  assign m_axis.tlast  = m_valid && (idx == LAST_IDX);
  assign s_axis.tready = s_ready;

  assign accept   = s_ready && s_axis.tvalid;
  assign cnt_next = pixel_count + FB_AW'(1);
  assign is_final = (cnt_next == expected);
  assign is_early = s_axis.tlast && (cnt_next < expected);

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      idx         <= '0;
      expected    <= '0;
      m_valid     <= 1'b0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_dim     <= 1'b0;
      err_early   <= 1'b0;
      err_nolast  <= 1'b0;
      pixel_count <= '0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_wdata    <= '0;
    end else begin
      fb_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (width == 16'd0 || height == 16'd0) begin
              err_dim <= 1'b1;
              state   <= ST_FINISH;
            end else begin
              expected    <= area;
              err_dim     <= 1'b0;
              err_early   <= 1'b0;
              err_nolast  <= 1'b0;
              pixel_count <= '0;
              idx         <= '0;
              m_valid     <= 1'b1;
              state       <= ST_SEND_CFG;
            end
          end
        end
        ST_SEND_CFG: begin
          if (m_valid && m_axis.tready) begin
            if (idx == LAST_IDX) begin
              m_valid <= 1'b0;
              s_ready <= 1'b1;
              idx     <= '0;
              state   <= ST_RECV_PIX;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        ST_RECV_PIX: begin
          if (accept) begin
            fb_we       <= 1'b1;
            fb_addr     <= pixel_count;
            fb_wdata    <= s_axis.tdata;
            pixel_count <= cnt_next;
            // done is raised here so it lines up with the final frame-buffer write
            if (is_final || is_early) begin
              s_ready <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= ST_FINISH;
              if (is_final && !s_axis.tlast) err_nolast <= 1'b1;
              if (!is_final)                 err_early  <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          // A dimension error arrives here without done; give it its pulse first
          if (done) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rt_scene_driver.sv
// Directed and randomized frames for rt_scene_driver against a behavioural
// model of the config stream, fragment acceptance and error rules.
module tb_rt_scene_driver;

  localparam int W  = 32;
  localparam int AW = 20;
  localparam int NW = 27;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cfg_we = 1'b0;
  logic [4:0]    cfg_addr = '0;
  logic [W-1:0]  cfg_wdata = '0;
  logic          start = 1'b0;
  logic          busy, done, err_dim, err_early, err_nolast, fb_we;
  logic [AW-1:0] pixel_count, fb_addr;
  logic [W-1:0]  fb_wdata;

  rt_scene_driver_if #(.WORD_LEN(W)) m_if ();
  rt_scene_driver_if #(.WORD_LEN(W)) s_if ();

  rt_scene_driver #(.WORD_LEN(W), .PAYLOAD_WORDS(NW), .FB_AW(AW)) dut (
    .aclk        (clk),
    .resetn      (resetn),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err_dim     (err_dim),
    .err_early   (err_early),
    .err_nolast  (err_nolast),
    .pixel_count (pixel_count),
    .m_axis      (m_if),
    .s_axis      (s_if),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_wdata    (fb_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  cfg_model [NW];
  logic [W-1:0]  pix [32];
  logic [W-1:0]  m_data_q [$];
  logic          m_last_q [$];
  int            m_cyc_q [$];
  logic [AW-1:0] fb_addr_q [$];
  logic [W-1:0]  fb_data_q [$];
  int            fb_cyc_q [$];
  int            done_cnt = 0;
  int            done_cyc = -1;
  int            sready_cyc = -1;
  bit            pend = 0;
  logic [W-1:0]  pend_data;
  logic          pend_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observer: records every handshake/write and enforces AXIS hold rules on m_axis
  always @(negedge clk) begin
    if (!resetn) begin
      pend = 0;
    end else begin
      if (pend) begin
        check("hold_valid", m_if.tvalid, 1);
        check("hold_data", m_if.tdata, pend_data);
        check("hold_last", m_if.tlast, pend_last);
      end
      pend      = m_if.tvalid && !m_if.tready;
      pend_data = m_if.tdata;
      pend_last = m_if.tlast;
      if (m_if.tvalid && m_if.tready) begin
        m_data_q.push_back(m_if.tdata);
        m_last_q.push_back(m_if.tlast);
        m_cyc_q.push_back(cyc);
      end
      if (fb_we) begin
        fb_addr_q.push_back(fb_addr);
        fb_data_q.push_back(fb_wdata);
        fb_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (s_if.tready && sready_cyc < 0) sready_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    m_data_q.delete();
    m_last_q.delete();
    m_cyc_q.delete();
    fb_addr_q.delete();
    fb_data_q.delete();
    fb_cyc_q.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    sready_cyc = -1;
  endtask

  task automatic write_cfg(input int a, input logic [W-1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = 5'(a);
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    if (a < NW) cfg_model[a] = d;
  endtask

  task automatic load_cfg(input int w, input int h);
    for (int i = 0; i < NW; i++) write_cfg(i, $urandom);
    write_cfg(1, 32'(w));
    write_cfg(2, 32'(h));
  endtask

  task automatic pulse_start(output int t);
    start = 1'b1;
    t = cyc;
    tick();
    start = 1'b0;
  endtask

  // One frame: last_beat = 0 means the coprocessor never sets tlast
  task automatic run_frame(input string name, input int w, input int h,
                           input int last_beat, input int n_offer, input bit toggle);
    int  exp_n, acc, b, t0;
    bit  early, nolast, hs;
    load_cfg(w, h);
    for (int i = 0; i < 32; i++) pix[i] = $urandom;

    exp_n = w * h;
    acc = 0; early = 0; nolast = 0;
    for (int k = 1; k <= n_offer; k++) begin
      if (k == exp_n) begin acc = k; nolast = (k != last_beat); break; end
      if (k == last_beat) begin acc = k; early = 1; break; end
    end

    clear_mon();
    m_if.tready = 1'b1;
    b = 0;
    s_if.tvalid = (n_offer > 0);
    s_if.tdata  = pix[0];
    s_if.tlast  = (last_beat == 1);
    pulse_start(t0);
    check({name, " busy_T1"}, busy, 1);
    check({name, " tvalid_T1"}, m_if.tvalid, 1);
    check({name, " word0_T1"}, m_if.tdata, cfg_model[0]);

    for (int c = 0; c < 600 && done_cnt == 0; c++) begin
      @(negedge clk);
      hs = s_if.tvalid && s_if.tready;
      tick();
      if (hs) b++;
      s_if.tvalid = (b < n_offer);
      s_if.tdata  = pix[b];
      s_if.tlast  = (b + 1 == last_beat);
      m_if.tready = toggle ? !m_if.tready : 1'b1;
    end
    m_if.tready = 1'b1;
    repeat (3) tick();

    check({name, " done_once"}, done_cnt, 1);
    check({name, " busy_end"}, busy, 0);
    check({name, " sready_end"}, s_if.tready, 0);
    check({name, " m_beats"}, m_data_q.size(), NW);
    for (int i = 0; i < NW && i < m_data_q.size(); i++) begin
      check($sformatf("%s word%0d", name, i), m_data_q[i], cfg_model[i]);
      check($sformatf("%s last%0d", name, i), m_last_q[i], (i == NW - 1));
    end
    check({name, " fb_writes"}, fb_addr_q.size(), acc);
    for (int i = 0; i < acc && i < fb_addr_q.size(); i++) begin
      check($sformatf("%s fb_addr%0d", name, i), fb_addr_q[i], i);
      check($sformatf("%s fb_data%0d", name, i), fb_data_q[i], pix[i]);
    end
    if (fb_cyc_q.size() > 0) check({name, " done_with_last_fb"}, done_cyc, fb_cyc_q[fb_cyc_q.size() - 1]);
    check({name, " pixel_count"}, pixel_count, acc);
    check({name, " err_early"}, err_early, early);
    check({name, " err_nolast"}, err_nolast, nolast);
    check({name, " err_dim"}, err_dim, 0);
    if (!toggle && m_cyc_q.size() == NW) begin
      check({name, " first_word_cyc"}, m_cyc_q[0], t0 + 1);
      check({name, " last_word_cyc"}, m_cyc_q[NW - 1], t0 + NW);
      check({name, " sready_rise_cyc"}, sready_cyc, t0 + NW + 1);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    tick();
  endtask

  initial begin
    int t0, w, h, lb;
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    for (int i = 0; i < NW; i++) cfg_model[i] = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    tick();

    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err_dim", err_dim, 0);
    check("rst err_early", err_early, 0);
    check("rst err_nolast", err_nolast, 0);
    check("rst pixel_count", pixel_count, 0);
    check("rst m_tvalid", m_if.tvalid, 0);
    check("rst m_tdata", m_if.tdata, 0);
    check("rst m_tlast", m_if.tlast, 0);
    check("rst s_tready", s_if.tready, 0);
    check("rst fb_we", fb_we, 0);
    check("rst fb_addr", fb_addr, 0);
    check("rst fb_wdata", fb_wdata, 0);

    // Config is all zero after reset, so the first start is a dimension error
    clear_mon();
    m_if.tready = 1'b1;
    pulse_start(t0);
    repeat (4) tick();
    check("post_rst err_dim", err_dim, 1);
    check("post_rst done", done_cnt, 1);
    check("post_rst m_beats", m_data_q.size(), 0);

    run_frame("basic", 4, 2, 8, 8, 1'b0);
    run_frame("toggle", 4, 2, 8, 8, 1'b1);
    run_frame("early", 4, 2, 5, 8, 1'b0);
    run_frame("nolast", 4, 2, 0, 10, 1'b0);
    for (int r = 0; r < 5; r++) begin
      w  = $urandom_range(1, 4);
      h  = $urandom_range(1, 3);
      lb = $urandom_range(0, w * h + 1);
      run_frame($sformatf("rand%0d", r), w, h, lb, w * h + 2, 1'($urandom_range(0, 1)));
    end

    write_cfg(1, 32'd0);
    clear_mon();
    pulse_start(t0);
    repeat (5) tick();
    check("dim err_dim", err_dim, 1);
    check("dim done_once", done_cnt, 1);
    check("dim done_cyc", done_cyc, t0 + 2);
    check("dim m_beats", m_data_q.size(), 0);
    check("dim busy", busy, 0);

    load_cfg(4, 2);
    clear_mon();
    m_if.tready = 1'b1;
    pulse_start(t0);
    for (int c = 0; c < 100 && m_data_q.size() < 10; c++) tick();
    check("midrst reached_word10", m_data_q.size(), 10);
    #2 resetn = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst m_tvalid", m_if.tvalid, 0);
    check("midrst m_tdata", m_if.tdata, 0);
    check("midrst m_tlast", m_if.tlast, 0);
    check("midrst s_tready", s_if.tready, 0);
    check("midrst pixel_count", pixel_count, 0);
    check("midrst fb_we", fb_we, 0);
    check("midrst err_dim", err_dim, 0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < NW; i++) cfg_model[i] = '0;
    tick();
    clear_mon();
    pulse_start(t0);
    repeat (5) tick();
    check("midrst restart err_dim", err_dim, 1);
    check("midrst restart done", done_cnt, 1);
    check("midrst restart m_beats", m_data_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rt_scene_driver.md
# rt_scene_driver

Host-side counterpart of the ray-tracing coprocessor's AXIS link. Holds the 27-word camera configuration in a local register file and streams it out on an AXIS master. It then sinks the returned pixel fragment stream on an AXIS slave, writes each pixel to a frame-buffer write port, and checks the fragment count and `tlast` against `image_width * image_height`. It sits between a CPU-visible control interface and the coprocessor's `s_axis`/`m_axis` pair.

## Interface
- `WORD_LEN`, 32: AXIS and config word width.
- `PAYLOAD_WORDS`, 27: camera payload length in words.
- `FB_AW`, 20: frame-buffer address width; also the width of `pixel_count`.
- `aclk` in 1: single clock for all logic.
- `resetn` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: config register write strobe; ignored while `busy`.
- `cfg_addr` in 5: word offset 0..26; writes to 27..31 are ignored.
- `cfg_wdata` in `WORD_LEN`: config word.
- `start` in 1: single-cycle pulse that launches a frame; ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at frame end.
- `err_dim` out 1: sticky until the next `start`; width or height was zero.
- `err_early` out 1: sticky; `tlast` arrived before the expected pixel count.
- `err_nolast` out 1: sticky; final expected pixel arrived without `tlast`.
- `pixel_count` out `FB_AW`: number of pixels accepted in the current or last frame.
- `m_axis_tvalid` out 1, `m_axis_tdata` out `WORD_LEN`, `m_axis_tlast` out 1, `m_axis_tready` in 1: config stream to the coprocessor.
- `s_axis_tvalid` in 1, `s_axis_tdata` in `WORD_LEN`, `s_axis_tlast` in 1, `s_axis_tready` out 1: fragment stream from the coprocessor.
- `fb_we` out 1, `fb_addr` out `FB_AW`, `fb_wdata` out `WORD_LEN`: frame-buffer write port.

## Operation
- States: IDLE, SEND_CFG, RECV_PIX, FINISH.
- **IDLE**
  - `start` with width and height both non-zero:
    - latch `expected = image_width[15:0] * image_height[15:0]`, 32-bit product, truncated to `FB_AW`;
    - clear the three error flags and `pixel_count`;
    - go to SEND_CFG.
  - `start` with width or height zero: set `err_dim` and go to FINISH. No AXIS beats are produced.
- **SEND_CFG**
  - Drive word `idx` (0..26) on `m_axis_tdata`, with `m_axis_tvalid=1`.
  - `m_axis_tlast=1` only on word 26.
  - `idx` advances on each handshake (`tvalid & tready`).
  - After the handshake on word 26: drop `tvalid` and go to RECV_PIX.
- **RECV_PIX**
  - `s_axis_tready=1`.
  - Each accepted beat:
    - registered write `fb_addr = pixel_count`, `fb_wdata = tdata`;
    - then `pixel_count` increments.
  - Frame end is the first of the following two events.
  - Accepted beat with `tlast=1` when `pixel_count+1 < expected`:
    - set `err_early`;
    - go to FINISH.
  - Accepted beat when `pixel_count+1 == expected`:
    - set `err_nolast` if `tlast=0`;
    - go to FINISH.
    - Any further beats are not accepted; `tready` stays 0.
- **FINISH**: pulse `done`, drop `busy`, return to IDLE.
- Config registers hold their values across frames and are cleared only by reset.

## Timing
- Reset values:
  - all outputs 0, state IDLE, `idx=0`;
  - config registers 0, so a `start` after reset raises `err_dim`.
- `start` at cycle T: `busy=1` and `m_axis_tvalid=1` carrying word 0 at T+1.
- With `m_axis_tready` held high, 27 words go out in cycles T+1..T+27.
- `s_axis_tready` rises the cycle after the word-26 handshake.
- AXIS master rules:
  - `tdata`/`tlast` are stable while `tvalid && !tready`;
  - `tvalid` is never withdrawn before its handshake.
- `s_axis_tready` is registered. It is deasserted in the cycle after the final accepted beat.
- `fb_we` follows its accepted beat by 1 cycle. The final `fb_we` coincides with `done`.
- Reset asserted mid-frame: all state clears immediately. Host and coprocessor are reset together.

## Structure
- Shared package `rt_pkg`:
  - payload offsets (`OFF_IMAGE_WIDTH=1`, `OFF_IMAGE_HEIGHT=2`, …, `OFF_PIXEL_00_LOC=24`);
  - `CameraPayloadSize=27`;
  - the driver state enum.
- One sub-module, `rt_cfg_regfile`: 27×`WORD_LEN` registers with a write port and two read ports, one for the streamed word and one for width/height.

## Test plan
- Width 4, height 2; ready always high; coprocessor model returns 8 beats with `tlast` on beat 8:
  - 27 config words equal the written values, with `tlast` only on word 26;
  - `fb_addr` 0..7 carry the returned data;
  - `done` pulses once, `pixel_count=8`, no errors.
- `m_axis_tready` toggled every cycle: each word is held stable until its handshake; the full config sequence is still correct.
- Width 4, height 2; `tlast` on beat 5: `err_early=1`, `pixel_count=5`, `done` pulses, 5 frame-buffer writes.
- Width 4, height 2; no `tlast`; model offers 10 beats: 8 beats accepted, `err_nolast=1`, `s_axis_tready=0` afterwards.
- Width 0: `err_dim=1`, `done` 2 cycles after `start`, zero `m_axis` handshakes.
- `resetn` pulsed low during SEND_CFG word 10: all outputs 0 immediately; a new `start` without rewriting config raises `err_dim`.
